// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the RV32I MM stage.
// Word-organised RAM (byte-strobed writes, combinational read) plus an MMIO
// window holding a 64-bit timer with compare interrupt and a byte TX FIFO.
module riscv_dmem_responder #(
  parameter int          DMEM_AW    = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_wr_en,
  input  logic [3:0]  i_dmem_strb,
  input  logic [31:0] i_dmem_wr_data,
  output logic [31:0] o_dmem_rd_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_timer_irq
);

  localparam int RAM_WORDS = 1 << DMEM_AW;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = PW + 1;

  // Word selects inside the MMIO window (offset[15:2]).
  localparam logic [13:0] SEL_TIME_LO = 14'd0;
  localparam logic [13:0] SEL_TIME_HI = 14'd1;
  localparam logic [13:0] SEL_CMP_LO  = 14'd2;
  localparam logic [13:0] SEL_CMP_HI  = 14'd3;
  localparam logic [13:0] SEL_TX_DATA = 14'd4;
  localparam logic [13:0] SEL_STATUS  = 14'd5;

  // Overwrite only the strobed bytes of a 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    merge_bytes = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) merge_bytes[k*8 +: 8] = new_word[k*8 +: 8];
    end
  endfunction

  // ---------------------------------------------------------------- decode
  logic               mmio_hit;
  logic [DMEM_AW-1:0] ram_idx;
  logic [13:0]        reg_sel;
  logic               wr_mmio;
  logic               ram_we;
  logic               unused_addr_bits;

  assign mmio_hit         = (i_dmem_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_idx          = i_dmem_addr[DMEM_AW+1:2];
  assign reg_sel          = i_dmem_addr[15:2];
  assign wr_mmio          = i_dmem_wr_en && mmio_hit;
  // A write coinciding with reset is dropped, like every other update.
  assign ram_we           = i_dmem_wr_en && !mmio_hit && i_rstn;
  assign unused_addr_bits = ^i_dmem_addr[1:0];

  logic wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;
  assign wr_time_lo = wr_mmio && (reg_sel == SEL_TIME_LO);
  assign wr_time_hi = wr_mmio && (reg_sel == SEL_TIME_HI);
  assign wr_cmp_lo  = wr_mmio && (reg_sel == SEL_CMP_LO);
  assign wr_cmp_hi  = wr_mmio && (reg_sel == SEL_CMP_HI);

  // ------------------------------------------------------------------- RAM
  // One byte-wide array per lane so each strobe owns its own storage.
  logic [31:0] ram_rd_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [RAM_WORDS];

      // Byte-lane write; contents are deliberately not reset.
      always_ff @(posedge i_clk) begin
        if (ram_we && i_dmem_strb[gi]) lane_mem[ram_idx] <= i_dmem_wr_data[gi*8 +: 8];
      end

      assign ram_rd_word[gi*8 +: 8] = lane_mem[ram_idx];
    end
  endgenerate

  // ----------------------------------------------------------- timer / cmp
  logic [63:0] time_reg, time_next;
  logic [63:0] cmp_reg, cmp_next;
  logic        irq_reg;

  // A TIME write replaces the increment for that cycle; CMP just merges.
  always_comb begin
    time_next = time_reg + 64'd1;
    if (wr_time_lo || wr_time_hi) begin
      time_next = time_reg;
      if (wr_time_lo) time_next[31:0]  = merge_bytes(time_reg[31:0],  i_dmem_wr_data, i_dmem_strb);
      if (wr_time_hi) time_next[63:32] = merge_bytes(time_reg[63:32], i_dmem_wr_data, i_dmem_strb);
    end
    cmp_next = cmp_reg;
    if (wr_cmp_lo) cmp_next[31:0]  = merge_bytes(cmp_reg[31:0],  i_dmem_wr_data, i_dmem_strb);
    if (wr_cmp_hi) cmp_next[63:32] = merge_bytes(cmp_reg[63:32], i_dmem_wr_data, i_dmem_strb);
  end

  // Timer, compare and interrupt registers; irq uses post-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      time_reg <= 64'd0;
      cmp_reg  <= '1;
      irq_reg  <= 1'b0;
    end else begin
      time_reg <= time_next;
      cmp_reg  <= cmp_next;
      irq_reg  <= (time_next >= cmp_next);
    end
  end

  // --------------------------------------------------------------- TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          fifo_full, fifo_empty;
  logic          push_req, push, pop, ovf_set, ovf_clr;

  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && i_tx_ready;
  assign push_req   = wr_mmio && (reg_sel == SEL_TX_DATA) && i_dmem_strb[0];
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign ovf_clr    = wr_mmio && (reg_sel == SEL_STATUS) && i_dmem_strb[0] && i_dmem_wr_data[7];

  // FIFO storage; reset clears every slot so the head byte reads 0.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
    end else if (push) begin
      fifo_mem[wr_ptr_reg] <= i_dmem_wr_data[7:0];
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (!push && pop) count_reg <= count_reg - CW'(1);
      if (ovf_set)      ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign o_tx_data   = fifo_mem[rd_ptr_reg];
  assign o_tx_valid  = !fifo_empty;
  assign o_timer_irq = irq_reg;

  // ------------------------------------------------------------- read mux
  // RAM by default; MMIO registers when the window is hit.
  always_comb begin
    o_dmem_rd_data = ram_rd_word;
    if (mmio_hit) begin
      case (reg_sel)
        SEL_TIME_LO: o_dmem_rd_data = time_reg[31:0];
        SEL_TIME_HI: o_dmem_rd_data = time_reg[63:32];
        SEL_CMP_LO:  o_dmem_rd_data = cmp_reg[31:0];
        SEL_CMP_HI:  o_dmem_rd_data = cmp_reg[63:32];
        SEL_STATUS:  o_dmem_rd_data = {23'd0, irq_reg, ovf_reg, 5'(count_reg), fifo_empty, fifo_full};
        default:     o_dmem_rd_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: stimulus queues expected results,
// a negedge monitor compares them against the DUT as outputs appear.
module tb_riscv_dmem_responder;

  localparam logic [31:0] A_TIME_LO = 32'hFFFF_0000;
  localparam logic [31:0] A_TIME_HI = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP_LO  = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP_HI  = 32'hFFFF_000C;
  localparam logic [31:0] A_TX      = 32'hFFFF_0010;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_0014;

  localparam int K_RD = 0, K_IRQ = 1, K_VALID = 2, K_TXD = 3;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [31:0] i_dmem_addr;
  logic        i_dmem_wr_en;
  logic [3:0]  i_dmem_strb;
  logic [31:0] i_dmem_wr_data;
  logic [31:0] o_dmem_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_timer_irq;

  riscv_dmem_responder dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_dmem_addr    (i_dmem_addr),
    .i_dmem_wr_en   (i_dmem_wr_en),
    .i_dmem_strb    (i_dmem_strb),
    .i_dmem_wr_data (i_dmem_wr_data),
    .o_dmem_rd_data (o_dmem_rd_data),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_timer_irq    (o_timer_irq)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] tx_q[$];
  logic       chk_req = 1'b0;
  int         n_vec   = 0;
  int         n_miss  = 0;

  // Monitor: compares a queued check when requested, and every TX handshake.
  always @(negedge i_clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    logic [7:0]  exp_b;
    if (chk_req) begin
      n_vec++;
      if (chk_q.size() == 0) begin
        n_miss++;
        $display("FAIL check_queue: got empty queue, required a pending check");
      end else begin
        c = chk_q.pop_front();
        case (c.kind)
          K_RD:    act = o_dmem_rd_data;
          K_IRQ:   act = {31'd0, o_timer_irq};
          K_VALID: act = {31'd0, o_tx_valid};
          default: act = {24'd0, o_tx_data};
        endcase
        if (act !== c.exp) begin
          n_miss++;
          $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
        end else begin
          $display("ok   %s = %h", c.name, act);
        end
      end
    end
    if (o_tx_valid && i_tx_ready) begin
      n_vec++;
      if (tx_q.size() == 0) begin
        n_miss++;
        $display("FAIL tx_pop: got unexpected byte %h, required no transfer", o_tx_data);
      end else begin
        exp_b = tx_q.pop_front();
        if (o_tx_data !== exp_b) begin
          n_miss++;
          $display("FAIL tx_pop: got %h, required %h", o_tx_data, exp_b);
        end else begin
          $display("ok   tx_pop = %h", o_tx_data);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    i_dmem_addr = addr; i_dmem_wr_data = data; i_dmem_strb = strb; i_dmem_wr_en = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_wr_en = 1'b0; i_dmem_strb = 4'd0;
  endtask

  task automatic push_chk(input string name, input int kind, input logic [31:0] exp);
    chk_t c;
    c.kind = kind; c.exp = exp; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic chk(input string name, input int kind, input logic [31:0] addr, input logic [31:0] exp);
    i_dmem_addr = addr; i_dmem_wr_en = 1'b0; i_dmem_strb = 4'd0;
    push_chk(name, kind, exp);
    chk_req = 1'b1;
    @(posedge i_clk); #1;
    chk_req = 1'b0;
  endtask

  // Write and read the same address in one cycle: read must show old data.
  task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_old);
    i_dmem_addr = addr; i_dmem_wr_data = data; i_dmem_strb = 4'hF; i_dmem_wr_en = 1'b1;
    push_chk(name, K_RD, exp_old);
    chk_req = 1'b1;
    @(posedge i_clk); #1;
    chk_req = 1'b0; i_dmem_wr_en = 1'b0; i_dmem_strb = 4'd0;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit accepted);
    if (accepted) tx_q.push_back(b);
    wr(A_TX, {24'd0, b}, 4'b0001);
  endtask

  task automatic drain();
    i_tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      if (!o_tx_valid) break;
    end
    i_tx_ready = 1'b0;
    if (o_tx_valid) begin
      n_vec++; n_miss++;
      $display("FAIL drain_timeout: got o_tx_valid=1 after 20 cycles, required 0");
    end
  endtask

  initial begin
    i_rstn = 1'b0; i_dmem_addr = 32'd0; i_dmem_wr_en = 1'b0;
    i_dmem_strb = 4'd0; i_dmem_wr_data = 32'd0; i_tx_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;

    // Timer counts from 0 after reset; five edges later it reads 5.
    repeat (5) @(posedge i_clk); #1;
    chk("time_lo_cycle5", K_RD, A_TIME_LO, 32'd5);
    chk("reset_status", K_RD, A_STATUS, 32'h0000_0002);
    chk("reset_tx_valid", K_VALID, 32'd0, 32'd0);
    chk("reset_tx_data", K_TXD, 32'd0, 32'd0);
    chk("reset_irq", K_IRQ, 32'd0, 32'd0);
    chk("reset_cmp_hi", K_RD, A_CMP_HI, 32'hFFFF_FFFF);

    // RAM byte strobes and aliasing.
    wr(32'h0000_0040, 32'h1122_3344, 4'b1111);
    wr(32'h0000_0040, 32'hAABB_CCDD, 4'b0101);
    chk("ram_strobe", K_RD, 32'h0000_0040, 32'h11BB_33DD);
    chk("ram_alias", K_RD, 32'h0000_1040, 32'h11BB_33DD);
    wr(32'h0000_0080, 32'h1234_5678, 4'b1111);
    wr_chk("ram_same_cycle_old", 32'h0000_0080, 32'hCAFE_BABE, 32'h1234_5678);
    chk("ram_after_write", K_RD, 32'h0000_0080, 32'hCAFE_BABE);
    chk("mmio_unmapped", K_RD, 32'hFFFF_0020, 32'd0);

    // Timer write and carry into the high word.
    wr(A_TIME_HI, 32'h1, 4'hF);
    wr(A_TIME_LO, 32'hFFFF_FFFF, 4'hF);
    chk("time_hi_loaded", K_RD, A_TIME_HI, 32'h1);
    chk("time_hi_carry", K_RD, A_TIME_HI, 32'h2);
    chk("time_lo_wrapped", K_RD, A_TIME_LO, 32'h1);

    // Compare interrupt around time == 100.
    wr(A_TIME_HI, 32'h0, 4'hF);
    wr(A_CMP_HI, 32'h0, 4'hF);
    wr(A_CMP_LO, 32'd100, 4'hF);
    wr(A_TIME_LO, 32'd90, 4'hF);
    repeat (9) @(posedge i_clk); #1;
    chk("irq_time99", K_IRQ, 32'd0, 32'd0);
    chk("irq_time100", K_IRQ, 32'd0, 32'd1);
    chk("time_lo_101", K_RD, A_TIME_LO, 32'd101);
    wr(A_CMP_LO, 32'hFFFF_FFFF, 4'hF);
    wr(A_CMP_HI, 32'hFFFF_FFFF, 4'hF);
    chk("irq_cleared", K_IRQ, 32'd0, 32'd0);

    // FIFO fill beyond capacity with the consumer stalled.
    for (int b = 8'h41; b <= 8'h45; b++) push_tx(8'(b), b != 8'h45);
    chk("status_full_ovf", K_RD, A_STATUS, 32'h0000_0091);
    chk("tx_head_stable", K_TXD, 32'd0, 32'h41);
    chk("tx_read_zero", K_RD, A_TX, 32'd0);
    drain();
    chk("drained_valid", K_VALID, 32'd0, 32'd0);
    chk("status_empty_ovf", K_RD, A_STATUS, 32'h0000_0082);
    wr(A_STATUS, 32'h0000_0080, 4'b0001);
    chk("status_ovf_cleared", K_RD, A_STATUS, 32'h0000_0002);

    // Full FIFO with simultaneous push and pop.
    for (int b = 8'h61; b <= 8'h64; b++) push_tx(8'(b), 1'b1);
    chk("status_full", K_RD, A_STATUS, 32'h0000_0011);
    i_tx_ready = 1'b1;
    push_tx(8'h5A, 1'b1);
    i_tx_ready = 1'b0;
    chk("status_full_pushpop", K_RD, A_STATUS, 32'h0000_0011);
    drain();

    // Reset in the middle of activity.
    wr(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    for (int b = 8'h71; b <= 8'h73; b++) push_tx(8'(b), 1'b0);
    i_dmem_addr = A_TX; i_dmem_wr_data = 32'h74; i_dmem_strb = 4'b0001; i_dmem_wr_en = 1'b1;
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1; i_dmem_wr_en = 1'b0; i_dmem_strb = 4'd0;
    chk("rst2_time_lo", K_RD, A_TIME_LO, 32'd0);
    chk("rst2_time_lo_next", K_RD, A_TIME_LO, 32'd1);
    chk("rst2_status", K_RD, A_STATUS, 32'h0000_0002);
    chk("rst2_tx_valid", K_VALID, 32'd0, 32'd0);
    chk("rst2_tx_data", K_TXD, 32'd0, 32'd0);
    chk("rst2_irq", K_IRQ, 32'd0, 32'd0);
    chk("rst2_ram_kept", K_RD, 32'h0000_0100, 32'hDEAD_BEEF);

    repeat (3) @(posedge i_clk); #1;
    n_vec++;
    if (tx_q.size() != 0 || chk_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover: got %0d tx / %0d checks pending, required 0 / 0", tx_q.size(), chk_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion after 200000 time units, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
